// File: rtl/mc_control_fsm.sv
// Multi-cycle RISC-V control FSM.
// Sequences IF/ID/EX/MEM/WB/PCU for one instruction at a time and drives
// the datapath strobes combinationally from the current state and inputs.
// A saturating stall counter guards the IF and MEM memory waits; if memory
// stays busy for STALL_LIMIT cycles the machine halts with a sticky mem_error.
module mc_control_fsm #(
  parameter int STALL_LIMIT = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic       alu_bcond,
  input  logic       ecall_halt,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_source,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic       mem_to_reg,
  output logic       pc_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op_sel,
  output logic       is_halted,
  output logic       mem_error,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_PCU  = 3'd5,
    S_HALT = 3'd6,
    S_BAD  = 3'd7
  } state_t;

  localparam logic [6:0] OP_ARITH  = 7'b0110011;
  localparam logic [6:0] OP_ARITHI = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_ECALL  = 7'b1110011;

  localparam logic [1:0] SRCB_RS2 = 2'b00;
  localparam logic [1:0] SRCB_4   = 2'b01;
  localparam logic [1:0] SRCB_IMM = 2'b10;
  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_BR   = 2'b01;
  localparam logic [1:0] ALU_FN   = 2'b10;

  // Counter wide enough for the limit, never narrower than 8 bits.
  localparam int CW = ($clog2(STALL_LIMIT + 1) > 8) ? $clog2(STALL_LIMIT + 1) : 8;
  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic [CW:0]   LIMIT   = (CW+1)'(STALL_LIMIT);

  state_t        cur, nxt;
  logic [CW-1:0] stall_cnt;
  logic          mem_err_q;
  logic          stalled;
  logic          timeout;
  logic          is_load, is_store;

  assign is_load  = (opcode == OP_LOAD);
  assign is_store = (opcode == OP_STORE);

  // A stall is a memory-wait state with memory still busy; this cycle is the
  // limit cycle when it would be stall number STALL_LIMIT.
  assign stalled = ((cur == S_IF) || (cur == S_MEM)) && !mem_ready;
  assign timeout = stalled && (({1'b0, stall_cnt} + {{CW{1'b0}}, 1'b1}) >= LIMIT);

  // Next-state selection; a ready handshake always beats the timeout because
  // timeout already requires mem_ready=0.
  always_comb begin
    nxt = cur;
    case (cur)
      S_IF: begin
        if (timeout)        nxt = S_HALT;
        else if (mem_ready) nxt = S_ID;
      end
      S_ID: begin
        case (opcode)
          OP_ECALL: nxt = ecall_halt ? S_HALT : S_PCU;
          OP_ARITH, OP_ARITHI, OP_LOAD, OP_STORE,
          OP_BRANCH, OP_JAL, OP_JALR: nxt = S_EX;
          default:  nxt = S_PCU;
        endcase
      end
      S_EX: begin
        case (opcode)
          OP_ARITH, OP_ARITHI: nxt = S_WB;
          OP_LOAD, OP_STORE:   nxt = S_MEM;
          OP_BRANCH:           nxt = alu_bcond ? S_IF : S_PCU;
          OP_JAL, OP_JALR:     nxt = S_IF;
          default:             nxt = S_PCU;
        endcase
      end
      S_MEM: begin
        if (timeout)        nxt = S_HALT;
        else if (mem_ready) nxt = is_load ? S_WB : S_PCU;
      end
      S_WB:    nxt = S_PCU;
      S_PCU:   nxt = S_IF;
      S_HALT:  nxt = S_HALT;
      default: nxt = S_HALT;
    endcase
  end

  // State, stall counter and sticky memory-error flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur       <= S_IF;
      stall_cnt <= '0;
      mem_err_q <= 1'b0;
    end else begin
      cur <= nxt;
      if ((nxt != cur) || !stalled)
        stall_cnt <= '0;
      else if (stall_cnt != CNT_MAX)
        stall_cnt <= stall_cnt + 1'b1;
      if (timeout)
        mem_err_q <= 1'b1;
    end
  end

  // Datapath strobes decoded from state and inputs; held low during reset.
  always_comb begin
    pc_write   = 1'b0;
    pc_source  = 1'b0;
    i_or_d     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    pc_to_reg  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_RS2;
    alu_op_sel = ALU_ADD;
    is_halted  = 1'b0;
    if (!reset) begin
      case (cur)
        S_IF: begin
          mem_read = 1'b1;
          ir_write = mem_ready;
        end
        S_ID: begin
          // ALUOut captures PC+imm for branch/JAL targets.
          alu_src_b = SRCB_IMM;
        end
        S_EX: begin
          case (opcode)
            OP_ARITH: begin
              alu_src_a  = 1'b1;
              alu_op_sel = ALU_FN;
            end
            OP_ARITHI: begin
              alu_src_a  = 1'b1;
              alu_src_b  = SRCB_IMM;
              alu_op_sel = ALU_FN;
            end
            OP_LOAD, OP_STORE: begin
              alu_src_a = 1'b1;
              alu_src_b = SRCB_IMM;
            end
            OP_BRANCH: begin
              alu_src_a  = 1'b1;
              alu_op_sel = ALU_BR;
              pc_write   = alu_bcond;
              pc_source  = alu_bcond;
            end
            OP_JAL: begin
              pc_write  = 1'b1;
              pc_source = 1'b1;
              reg_write = 1'b1;
              pc_to_reg = 1'b1;
            end
            OP_JALR: begin
              alu_src_a = 1'b1;
              alu_src_b = SRCB_IMM;
              pc_write  = 1'b1;
              reg_write = 1'b1;
              pc_to_reg = 1'b1;
            end
            default: ;
          endcase
        end
        S_MEM: begin
          i_or_d    = 1'b1;
          mem_read  = is_load;
          mem_write = is_store;
        end
        S_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = is_load;
        end
        S_PCU: begin
          alu_src_b = SRCB_4;
          pc_write  = 1'b1;
        end
        S_HALT:  is_halted = 1'b1;
        default: ;
      endcase
    end
  end

  assign mem_error = mem_err_q;
  assign state     = cur;

endmodule
